// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/flush scheduler: turns jumps, load-use hazards and multi-cycle
// EX ops into per-stage stall/flush commands for pc, if_id and id_ex.
module pipe_hazard_ctrl #(
    parameter int JUMP_FLUSH_CYC = 1,
    parameter int MC_TIMEOUT     = 64,
    parameter int CNT_W          = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        load_use_i,
    input  logic        mc_req_i,
    input  logic        mc_done_i,
    output logic        jump_en_o,
    output logic [31:0] jump_addr_o,
    output logic        stall_pc_o,
    output logic        stall_if_id_o,
    output logic        flush_if_id_o,
    output logic        stall_id_ex_o,
    output logic        flush_id_ex_o,
    output logic [1:0]  state_o,
    output logic        timeout_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FLUSH   = 2'd1,
        S_BUBBLE  = 2'd2,
        S_MC_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(JUMP_FLUSH_CYC - 1);
    localparam logic [CNT_W-1:0] MC_LIMIT     = CNT_W'(MC_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             timeout_q;
    logic             timeout_set;
    logic             jump_take;

    // Decode: Mealy commands plus next state; everything is forced low while rst is held.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        timeout_set   = 1'b0;
        jump_take     = 1'b0;
        stall_pc_o    = 1'b0;
        stall_if_id_o = 1'b0;
        stall_id_ex_o = 1'b0;
        flush_if_id_o = 1'b0;
        flush_id_ex_o = 1'b0;

        case (state)
            S_IDLE, S_BUBBLE: begin
                if (jump_en_i) begin
                    jump_take     = 1'b1;
                    flush_if_id_o = 1'b1;
                    flush_id_ex_o = 1'b1;
                    if (JUMP_FLUSH_CYC > 1) begin
                        state_nxt = S_FLUSH;
                        cnt_nxt   = FLUSH_RELOAD;
                    end else begin
                        state_nxt = S_IDLE;
                        cnt_nxt   = '0;
                    end
                end else if (state == S_BUBBLE) begin
                    // Bubble lasts one cycle and masks load_use so the pipe always advances.
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else if (mc_req_i && !mc_done_i) begin
                    stall_pc_o    = 1'b1;
                    stall_if_id_o = 1'b1;
                    stall_id_ex_o = 1'b1;
                    state_nxt     = S_MC_WAIT;
                    cnt_nxt       = CNT_ONE;
                end else if (mc_req_i) begin
                    state_nxt = S_IDLE;
                end else if (load_use_i) begin
                    stall_pc_o    = 1'b1;
                    stall_if_id_o = 1'b1;
                    flush_id_ex_o = 1'b1;
                    state_nxt     = S_BUBBLE;
                end
            end

            S_FLUSH: begin
                flush_if_id_o = 1'b1;
                flush_id_ex_o = 1'b1;
                if (jump_en_i) begin
                    jump_take = 1'b1;
                    cnt_nxt   = FLUSH_RELOAD;
                end else if (cnt <= CNT_ONE) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end

            S_MC_WAIT: begin
                // EX is frozen here, so jumps and load-use from downstream are not acted on.
                if (mc_done_i) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt >= MC_LIMIT) begin
                    flush_id_ex_o = 1'b1;
                    timeout_set   = 1'b1;
                    state_nxt     = S_IDLE;
                    cnt_nxt       = '0;
                end else begin
                    stall_pc_o    = 1'b1;
                    stall_if_id_o = 1'b1;
                    stall_id_ex_o = 1'b1;
                    cnt_nxt       = cnt + CNT_ONE;
                end
            end

            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase

        if (rst) begin
            jump_take     = 1'b0;
            timeout_set   = 1'b0;
            stall_pc_o    = 1'b0;
            stall_if_id_o = 1'b0;
            stall_id_ex_o = 1'b0;
            flush_if_id_o = 1'b0;
            flush_id_ex_o = 1'b0;
        end
    end

    assign jump_en_o   = jump_take;
    assign jump_addr_o = jump_take ? jump_addr_i : 32'd0;
    assign state_o     = rst ? 2'd0 : state;
    assign timeout_o   = timeout_q & ~rst;

    // State register: reset drops any in-flight flush or stall sequence.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            timeout_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (timeout_set) begin
                timeout_q <= 1'b1;
            end
        end
    end

endmodule
